// File: rtl/aes_frame_parser.sv
// -----------------------------------------------------------------------------
// aes_frame_parser
//
// Pops tagged words from a first-word-fall-through FIFO, decodes a frame
// header, loads the key and IV, and assembles 128-bit blocks for the AES round
// core. CBC chaining is applied before the core on encrypt. For decrypt and CTR
// the XOR mask is exported for the downstream stage.
//
// Parameters
//   WORD_W : payload word width (32 or 64); WPB = 128/WORD_W words per block
//   LEN_W  : width of the header block count and of the block counter
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   in_data, in_empty, rd_en: FIFO side; tag in [WORD_W+1:WORD_W]
//                             (01 header, 00 payload, 10 last payload, 11 rsvd)
//   key, key_mode, key_load : assembled key, size code, completion pulse
//   dir, chain_mode         : latched header fields
//   blk_data, blk_mask      : block to the core, post-XOR mask
//   blk_valid, blk_ready    : block handshake
//   blk_last                : qualifies the final block of the frame
//   chain_data, chain_valid : ciphertext feedback from the core (CBC encrypt)
//   frame_done              : pulse after the final block handshake
//   err, err_code           : error pulse and held error code
//   busy                    : high outside IDLE
//   dbg_state               : current FSM state for observation
//
// Optional feature macro: AES_CTR_EN (makes chain mode 2 = CTR legal).
//
// Block handshake: a block transfers on a rising edge where blk_valid and
// blk_ready are both high. Once blk_valid rises it stays high, with blk_data,
// blk_mask and blk_last unchanged, until that transfer happens.
// -----------------------------------------------------------------------------
module aes_frame_parser #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W+1:0] in_data,
    input  logic              in_empty,
    output logic              rd_en,
    output logic [255:0]      key,
    output logic [1:0]        key_mode,
    output logic              key_load,
    output logic              dir,
    output logic [1:0]        chain_mode,
    output logic [127:0]      blk_data,
    output logic [127:0]      blk_mask,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              blk_last,
    input  logic [127:0]      chain_data,
    input  logic              chain_valid,
    output logic              frame_done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int         WPB   = 128 / WORD_W;
    localparam logic [1:0] WLAST = 2'(WPB - 1);
    localparam logic [2:0] KL128 = 3'(128 / WORD_W - 1);
    localparam logic [2:0] KL192 = 3'(192 / WORD_W - 1);
    localparam logic [2:0] KL256 = 3'(256 / WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEY     = 3'd1,
        S_IV      = 3'd2,
        S_COLLECT = 3'd3,
        S_OUT     = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [255:0]       key_q, key_d;
    logic [1:0]         key_mode_q, key_mode_d;
    logic               key_load_q, key_load_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   nblk_q, nblk_d;
    logic [LEN_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [2:0]         k_cnt_q, k_cnt_d;
    logic [1:0]         w_cnt_q, w_cnt_d;
    logic [127:0]       iv_q, iv_d;
    logic [127:0]       raw_q, raw_d;
    logic [127:0]       prev_q, prev_d;
    logic [127:0]       chain_q, chain_d;
    logic               chain_seen_q, chain_seen_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;
    logic [2:0]         err_code_q, err_code_d;

    logic [1:0]         tag;
    logic [WORD_W-1:0]  pay;
    logic [LEN_W-1:0]   h_nblk;
    logic               h_dir;
    logic [2:0]         h_kc;
    logic [1:0]         h_cm;
    logic               kc_ok;
    logic               cm_ok;
    logic [1:0]         h_km;
    logic [2:0]         klast;
    logic               last_blk;
    logic               cbc_enc;
    logic               need_chain;
    logic               hs;

    assign tag    = in_data[WORD_W+1:WORD_W];
    assign pay    = in_data[WORD_W-1:0];
    assign h_nblk = pay[LEN_W-1:0];
    assign h_dir  = pay[LEN_W];
    assign h_kc   = pay[LEN_W+3:LEN_W+1];
    assign h_cm   = pay[LEN_W+5:LEN_W+4];

    // Header field legality and key-size decode.
    always_comb begin
        kc_ok = 1'b1;
        h_km  = 2'b00;
        case (h_kc)
            3'b101:  h_km = 2'b00;
            3'b100:  h_km = 2'b01;
            3'b011:  h_km = 2'b10;
            default: kc_ok = 1'b0;
        endcase
`ifdef AES_CTR_EN
        cm_ok = (h_cm != 2'd3);
`else
        cm_ok = (h_cm < 2'd2);
`endif
    end

    always_comb begin
        case (key_mode_q)
            2'b00:   klast = KL128;
            2'b01:   klast = KL192;
            default: klast = KL256;
        endcase
    end

    assign last_blk   = (blk_cnt_q == (nblk_q - LEN_W'(1)));
    assign cbc_enc    = (mode_q == 2'd1) && dir_q;
    // Block 0 of CBC encrypt uses the IV, so only later blocks wait on the core.
    assign need_chain = cbc_enc && (blk_cnt_q != '0);
    assign blk_valid  = (state_q == S_OUT) && (!need_chain || chain_seen_q);
    assign hs         = blk_valid && blk_ready;
    assign blk_last   = blk_valid && last_blk;

    // Header words are never popped mid-frame, so the next frame starts clean.
    always_comb begin
        rd_en = 1'b0;
        case (state_q)
            S_IDLE, S_KEY, S_IV:  rd_en = !in_empty;
            S_COLLECT, S_DRAIN:   rd_en = !in_empty && (tag != 2'b01);
            default:              rd_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        key_mode_d   = key_mode_q;
        key_load_d   = 1'b0;
        dir_d        = dir_q;
        mode_d       = mode_q;
        nblk_d       = nblk_q;
        blk_cnt_d    = blk_cnt_q;
        k_cnt_d      = k_cnt_q;
        w_cnt_d      = w_cnt_q;
        iv_d         = iv_q;
        raw_d        = raw_q;
        prev_d       = prev_q;
        chain_d      = chain_q;
        chain_seen_d = chain_seen_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;

        // Core feedback may arrive while the next block is still being
        // collected; capture the first strobe after each handshake.
        if (chain_valid && need_chain && !chain_seen_q &&
            (state_q == S_COLLECT || state_q == S_OUT)) begin
            chain_d      = chain_data;
            chain_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_en) begin
                    if (tag == 2'b01) begin
                        nblk_d       = h_nblk;
                        dir_d        = h_dir;
                        mode_d       = h_cm;
                        key_mode_d   = h_km;
                        key_d        = '0;
                        err_code_d   = 3'd0;
                        k_cnt_d      = '0;
                        w_cnt_d      = '0;
                        blk_cnt_d    = '0;
                        chain_seen_d = 1'b0;
                        if (!kc_ok) begin
                            err_d      = 1'b1;
                            err_code_d = 3'd2;
                        end else if (!cm_ok) begin
                            err_d      = 1'b1;
                            err_code_d = 3'd3;
                        end else if (h_nblk == '0) begin
                            err_d      = 1'b1;
                            err_code_d = 3'd4;
                        end else begin
                            state_d = S_KEY;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 3'd1;
                        if (tag != 2'b10) state_d = S_DRAIN;
                    end
                end
            end
            S_KEY: begin
                if (rd_en) begin
                    key_d[int'(k_cnt_q)*WORD_W +: WORD_W] = pay;
                    k_cnt_d = k_cnt_q + 3'd1;
                    if (k_cnt_q == klast) begin
                        key_load_d = 1'b1;
                        w_cnt_d    = '0;
                        state_d    = (mode_q == 2'd0) ? S_COLLECT : S_IV;
                    end
                end
            end
            S_IV: begin
                if (rd_en) begin
                    iv_d[int'(w_cnt_q)*WORD_W +: WORD_W] = pay;
                    if (w_cnt_q == WLAST) begin
                        w_cnt_d = '0;
                        state_d = S_COLLECT;
                    end else begin
                        w_cnt_d = w_cnt_q + 2'd1;
                    end
                end
            end
            S_COLLECT: begin
                if (!in_empty) begin
                    // Only the closing word of the final block may carry tag 10.
                    if (tag == ((last_blk && w_cnt_q == WLAST) ? 2'b10 : 2'b00)) begin
                        raw_d[int'(w_cnt_q)*WORD_W +: WORD_W] = pay;
                        if (w_cnt_q == WLAST) begin
                            w_cnt_d = '0;
                            state_d = S_OUT;
                        end else begin
                            w_cnt_d = w_cnt_q + 2'd1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 3'd5;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_OUT: begin
                if (hs) begin
                    prev_d       = raw_q;
                    chain_seen_d = 1'b0;
                    if (last_blk) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        blk_cnt_d = blk_cnt_q + LEN_W'(1);
                        state_d   = S_COLLECT;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_empty && (tag == 2'b01 || tag == 2'b10)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            key_mode_q   <= '0;
            key_load_q   <= 1'b0;
            dir_q        <= 1'b0;
            mode_q       <= '0;
            nblk_q       <= '0;
            blk_cnt_q    <= '0;
            k_cnt_q      <= '0;
            w_cnt_q      <= '0;
            iv_q         <= '0;
            raw_q        <= '0;
            prev_q       <= '0;
            chain_q      <= '0;
            chain_seen_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            key_mode_q   <= key_mode_d;
            key_load_q   <= key_load_d;
            dir_q        <= dir_d;
            mode_q       <= mode_d;
            nblk_q       <= nblk_d;
            blk_cnt_q    <= blk_cnt_d;
            k_cnt_q      <= k_cnt_d;
            w_cnt_q      <= w_cnt_d;
            iv_q         <= iv_d;
            raw_q        <= raw_d;
            prev_q       <= prev_d;
            chain_q      <= chain_d;
            chain_seen_q <= chain_seen_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    // Datapath selection by chaining mode; the default covers ECB.
    always_comb begin
        blk_data = raw_q;
        blk_mask = '0;
        case (mode_q)
            2'd1: begin
                if (dir_q) blk_data = raw_q ^ ((blk_cnt_q == '0) ? iv_q : chain_q);
                else       blk_mask = (blk_cnt_q == '0) ? iv_q : prev_q;
            end
`ifdef AES_CTR_EN
            2'd2: begin
                blk_data = {iv_q[127:32], iv_q[31:0] + 32'(blk_cnt_q)};
                blk_mask = raw_q;
            end
`endif
            default: ;
        endcase
    end

    assign key        = key_q;
    assign key_mode   = key_mode_q;
    assign key_load   = key_load_q;
    assign dir        = dir_q;
    assign chain_mode = mode_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_aes_frame_parser
//
// Frames are built by tasks that push words into a modelled FIFO. At the same
// time they push the expected key, blocks, error codes and frame count, all
// computed from the chaining rules. A single negedge process drives the FIFO,
// blk_ready and the core's chain feedback. It then pops and compares whenever
// the DUT presents a key_load, err or block handshake.
// -----------------------------------------------------------------------------
module tb_aes_frame_parser;

    localparam int W  = 32;
    localparam int LW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W+1:0]   in_data = '0;
    logic           in_empty = 1'b1;
    logic           rd_en;
    logic [255:0]   key;
    logic [1:0]     key_mode;
    logic           key_load;
    logic           dir;
    logic [1:0]     chain_mode;
    logic [127:0]   blk_data, blk_mask;
    logic           blk_valid;
    logic           blk_ready = 1'b0;
    logic           blk_last;
    logic [127:0]   chain_data = '0;
    logic           chain_valid = 1'b0;
    logic           frame_done, err;
    logic [2:0]     err_code;
    logic           busy;
    logic [2:0]     dbg_state;

    always #5 clk = ~clk;

    aes_frame_parser #(.WORD_W(W), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_empty(in_empty), .rd_en(rd_en),
        .key(key), .key_mode(key_mode), .key_load(key_load), .dir(dir),
        .chain_mode(chain_mode), .blk_data(blk_data), .blk_mask(blk_mask),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
        .chain_data(chain_data), .chain_valid(chain_valid), .frame_done(frame_done),
        .err(err), .err_code(err_code), .busy(busy), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [W+1:0]   fifo[$];
    logic [257:0]   exp_q[$];        // {chain_after, last, data, mask}
    logic [257:0]   exp_key_q[$];    // {key_mode, key}
    logic [2:0]     exp_err_q[$];
    logic [127:0]   chain_src_q[$];
    int             exp_done = 0;
    int             got_done = 0;
    bit             gap_en = 0;
    bit             gap_phase = 0;
    bit             rand_ready = 0;
    int             stall_left = 0;
    int             chain_delay = 0;
    int             chain_wait = 0;
    logic [127:0]   chain_hold = '0;
    bit             prev_stall = 0;
    logic [127:0]   prev_data, prev_mask;
    logic [257:0]   rec;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_hdr(input logic [2:0] kc, input logic [1:0] cm, input bit d, input int nblk);
        logic [31:0] hp;
        hp = '0;
        hp[7:0]   = 8'(nblk);
        hp[8]     = d;
        hp[11:9]  = kc;
        hp[13:12] = cm;
        fifo.push_back({2'b01, hp});
    endtask

    task automatic push_key(input logic [2:0] kc);
        logic [255:0] k;
        logic [31:0]  w;
        logic [1:0]   km;
        int           kw;
        case (kc)
            3'b101:  begin kw = 4; km = 2'd0; end
            3'b100:  begin kw = 6; km = 2'd1; end
            default: begin kw = 8; km = 2'd2; end
        endcase
        k = '0;
        for (int i = 0; i < kw; i++) begin
            w = $urandom();
            k[i*32 +: 32] = w;
            fifo.push_back({2'b00, w});
        end
        exp_key_q.push_back({km, k});
    endtask

    task automatic push_words(input int n, input logic [1:0] tg);
        for (int i = 0; i < n; i++) fifo.push_back({tg, $urandom()});
    endtask

    // Reference model: mask is IV for block 0, then the previous ciphertext
    // (encrypt) or previous input block (decrypt); CTR counts from the IV.
    task automatic send_frame(input logic [2:0] kc, input logic [1:0] cm, input bit d,
                              input int nblk, input bit iv_ones);
        logic [127:0] iv, raw, prev, chn, dat, msk;
        logic [1:0]   tg;
        bit           cha;
        push_hdr(kc, cm, d, nblk);
        push_key(kc);
        iv = rand128();
        if (iv_ones) iv[31:0] = 32'hffff_ffff;
        if (cm != 2'd0)
            for (int i = 0; i < 4; i++) fifo.push_back({2'b00, iv[i*32 +: 32]});
        prev = iv;
        chn  = iv;
        for (int n = 0; n < nblk; n++) begin
            raw = rand128();
            for (int i = 0; i < 4; i++) begin
                tg = (n == nblk - 1 && i == 3) ? 2'b10 : 2'b00;
                fifo.push_back({tg, raw[i*32 +: 32]});
            end
            dat = raw;
            msk = '0;
            if (cm == 2'd1 && d)  dat = raw ^ chn;
            else if (cm == 2'd1)  msk = prev;
            else if (cm == 2'd2) begin
                dat = {iv[127:32], iv[31:0] + 32'(n)};
                msk = raw;
            end
            prev = raw;
            cha  = (cm == 2'd1) && d && (n < nblk - 1);
            if (cha) begin
                chn = rand128();
                chain_src_q.push_back(chn);
            end
            exp_q.push_back({cha, (n == nblk - 1), dat, msk});
        end
        exp_done++;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || exp_err_q.size() != 0 ||
                exp_key_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got fifo=%0d blk=%0d err=%0d key=%0d pending, required none",
                     nm, fifo.size(), exp_q.size(), exp_err_q.size(), exp_key_q.size());
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_key"}, key, '0);
        chk({nm, "_blk"}, {blk_data, blk_mask}, '0);
        chk({nm, "_ctl"}, {key_mode, key_load, dir, chain_mode, blk_valid, blk_last,
                           frame_done, err, err_code, busy, rd_en}, '0);
    endtask

    // Drive phase at the negedge, then sample and score 1 ns later.
    always @(negedge clk) begin
        gap_phase = gap_en ? ~gap_phase : 1'b0;
        if (fifo.size() == 0 || gap_phase) begin
            in_empty = 1'b1;
            in_data  = {2'b11, $urandom()};
        end else begin
            in_empty = 1'b0;
            in_data  = fifo[0];
        end
        if (blk_valid && stall_left > 0) begin
            blk_ready = 1'b0;
            stall_left--;
        end else begin
            blk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chain_valid = 1'b0;
        if (chain_wait > 0) begin
            chain_wait--;
            if (chain_wait == 0) begin
                chain_valid = 1'b1;
                chain_data  = chain_hold;
            end
        end
        #1;
        if (!rst) begin
            if (in_empty) chk("rd_en_when_empty", rd_en, 0);
            if (rd_en && !in_empty) void'(fifo.pop_front());
            if (err) begin
                if (exp_err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_unexpected: got code %0d required no error", err_code);
                end else begin
                    chk("err_code", err_code, exp_err_q.pop_front());
                end
            end
            if (key_load) begin
                if (exp_key_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL key_load_unexpected: got pulse required none");
                end else begin
                    rec = exp_key_q.pop_front();
                    chk("key", key, rec[255:0]);
                    chk("key_mode", key_mode, rec[257:256]);
                    chk("err_code_cleared", err_code, 0);
                end
            end
            if (frame_done) got_done++;
            if (prev_stall) begin
                chk("valid_hold", blk_valid, 1);
                chk("data_hold", blk_data, prev_data);
                chk("mask_hold", blk_mask, prev_mask);
            end
            prev_stall = blk_valid && !blk_ready;
            prev_data  = blk_data;
            prev_mask  = blk_mask;
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL blk_unexpected: got %h required no block", blk_data);
                end else begin
                    rec = exp_q.pop_front();
                    chk("blk_data", blk_data, rec[255:128]);
                    chk("blk_mask", blk_mask, rec[127:0]);
                    chk("blk_last", blk_last, rec[256]);
                    if (rec[257] && chain_src_q.size() != 0) begin
                        chain_hold = chain_src_q.pop_front();
                        chain_wait = (chain_delay > 0) ? chain_delay : int'($urandom_range(1, 6));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [2:0] kc;
        logic [1:0] cm;
        repeat (3) @(negedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;

        // CBC encrypt, 128-bit key, core feedback three clocks after handshake.
        chain_delay = 3;
        send_frame(3'b101, 2'd1, 1'b1, 2, 1'b0);
        wait_idle("cbc_enc");
        chain_delay = 0;

        // 256-bit key, ECB, receiver stalls five cycles.
        stall_left = 5;
        send_frame(3'b011, 2'd0, 1'b0, 1, 1'b0);
        wait_idle("stall");

        // Bad key code, then a valid frame clears err_code.
        push_hdr(3'b111, 2'd1, 1'b0, 2);
        exp_err_q.push_back(3'd2);
        send_frame(3'b100, 2'd1, 1'b0, 2, 1'b0);
        wait_idle("bad_kc");

        // Reserved mode, zero length, stray payload and stray last word in IDLE.
        push_hdr(3'b101, 2'd3, 1'b0, 1);
        exp_err_q.push_back(3'd3);
        push_hdr(3'b101, 2'd0, 1'b0, 0);
        exp_err_q.push_back(3'd4);
        push_words(1, 2'b00);
        exp_err_q.push_back(3'd1);
        push_words(2, 2'b00);
        push_words(1, 2'b10);
        push_words(1, 2'b10);
        exp_err_q.push_back(3'd1);
        wait_idle("idle_errs");

        // Early tag 10 on word 4 of a two-block frame, drain, then a clean frame.
        push_hdr(3'b101, 2'd0, 1'b0, 2);
        push_key(3'b101);
        push_words(3, 2'b00);
        push_words(1, 2'b10);
        exp_err_q.push_back(3'd5);
        push_words(2, 2'b00);
        push_words(1, 2'b10);
        send_frame(3'b101, 2'd0, 1'b0, 1, 1'b0);
        wait_idle("early_last");

        // Header arriving mid-block is left in the FIFO and starts the next frame.
        push_hdr(3'b101, 2'd0, 1'b0, 1);
        push_key(3'b101);
        push_words(2, 2'b00);
        exp_err_q.push_back(3'd5);
        send_frame(3'b011, 2'd1, 1'b1, 2, 1'b0);
        wait_idle("mid_header");

        // Empty FIFO every other cycle through IV and data.
        gap_en = 1;
        send_frame(3'b101, 2'd1, 1'b0, 3, 1'b0);
        wait_idle("gaps");
        gap_en = 0;

`ifdef AES_CTR_EN
        send_frame(3'b101, 2'd2, 1'b1, 2, 1'b1);
        wait_idle("ctr");
`else
        push_hdr(3'b101, 2'd2, 1'b0, 2);
        exp_err_q.push_back(3'd3);
        wait_idle("ctr_off");
`endif

        // Randomized frames with random ready and feedback timing.
        rand_ready = 1;
        for (int f = 0; f < 10; f++) begin
            case ($urandom_range(0, 2))
                0:       kc = 3'b101;
                1:       kc = 3'b100;
                default: kc = 3'b011;
            endcase
`ifdef AES_CTR_EN
            cm = 2'($urandom_range(0, 2));
`else
            cm = 2'($urandom_range(0, 1));
`endif
            gap_en = 1'($urandom_range(0, 1));
            send_frame(kc, cm, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'b0);
            wait_idle("random");
        end
        gap_en = 0;
        rand_ready = 0;

        // Reset while collecting a block.
        push_hdr(3'b101, 2'd0, 1'b0, 2);
        push_key(3'b101);
        push_words(2, 2'b00);
        n = 0;
        while ((fifo.size() != 0 || exp_key_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk_zero("rst_mid");
        rst = 1'b0;
        send_frame(3'b101, 2'd1, 1'b1, 2, 1'b0);
        wait_idle("after_rst");

        chk("frames_done", got_done, exp_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1);
    end

endmodule
